// File: rtl/execute_ctrl_pkg.sv
// Shared types, opcode constants and the multiply-opcode decode used by the
// Execute sequencing controller and its helpers.
package execute_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, EXEC, MUL_WAIT, FLUSH, HALT} state_t;

  localparam logic [7:0] OP_F7 = 8'hF7;  // group 3 (MUL/IMUL via ModRM.reg)
  localparam logic [7:0] OP_6B = 8'h6B;  // IMUL r, r/m, imm8
  localparam logic [7:0] OP_69 = 8'h69;  // IMUL r, r/m, imm32
  localparam logic [7:0] OP_AF = 8'hAF;  // 0F AF IMUL r, r/m
  localparam logic [7:0] OP_74 = 8'h74;  // JE rel8
  localparam logic [7:0] OP_C3 = 8'hC3;  // RET
  localparam logic [7:0] OP_CB = 8'hCB;  // RETF
  localparam logic [7:0] OP_CF = 8'hCF;  // IRET

  function automatic logic is_mul_op(input logic [31:0] len, input logic [7:0] op,
                                     input logic hasExt, input logic [2:0] extOp);
    return (len == 32'd1 && op == OP_F7 && hasExt && (extOp == 3'b100 || extOp == 3'b101))
        || (len == 32'd1 && (op == OP_6B || op == OP_69))
        || (len == 32'd2 && op == OP_AF);
  endfunction

endpackage

// File: rtl/exec_op_classifier.sv
// Combinational opcode classifier: flags opcodes that need the multi-cycle
// multiply path.
module exec_op_classifier
  import execute_ctrl_pkg::*;
(
  input  logic [31:0] opcodeLength,
  input  logic [7:0]  opcode,
  input  logic        hasExtendedOpcode,
  input  logic [2:0]  extendedOpcode,
  output logic        isMul
);

  assign isMul = is_mul_op(opcodeLength, opcode, hasExtendedOpcode, extendedOpcode);

endmodule

// File: rtl/execute_ctrl.sv
// Execute-stage sequencer: Decode handshake, multiply latency insertion,
// writeback-stall hold, jump flush/redirect and kill halt.
module execute_ctrl
  import execute_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             decValidIn,
  output logic             decReadyOut,
  input  logic [7:0]       opcodeIn,
  input  logic [31:0]      opcodeLengthIn,
  input  logic             hasExtendedOpcodeIn,
  input  logic [2:0]       extendedOpcodeIn,
  input  logic             wbStallIn,
  input  logic             isExecuteSuccessfulIn,
  input  logic             didJumpIn,
  input  logic [63:0]      jumpTargetIn,
  input  logic             killIn,
  output logic             latchEnOut,
  output logic             canExecuteOut,
  output logic             flushOut,
  output logic             redirectValidOut,
  output logic [63:0]      redirectRipOut,
  output logic             haltedOut,
  output logic             illegalOut,
  output logic             mulBusyOut,
  output logic [CNT_W-1:0] retiredCountOut
);

  localparam logic [2:0] MUL_INIT = 3'(MUL_LATENCY - 1);

  state_t     state, nextState;
  logic [2:0] mulCnt, mulCntNext;
  logic       isMul, done, accept, retire, illegalNext, takeJump;

  exec_op_classifier uClassifier (
    .opcodeLength      (opcodeLengthIn),
    .opcode            (opcodeIn),
    .hasExtendedOpcode (hasExtendedOpcodeIn),
    .extendedOpcode    (extendedOpcodeIn),
    .isMul             (isMul)
  );

  always_comb begin
    done        = (state == EXEC) && isExecuteSuccessfulIn && !wbStallIn;
    decReadyOut = reset_n && !wbStallIn &&
                  (state == IDLE || (done && !didJumpIn && !killIn));
    accept      = decValidIn && decReadyOut;
    latchEnOut  = accept;

    nextState   = state;
    mulCntNext  = mulCnt;
    retire      = 1'b0;
    illegalNext = 1'b0;
    takeJump    = 1'b0;

    case (state)
      IDLE: ;
      EXEC: begin
        if (wbStallIn) begin
          nextState = EXEC;
        end else if (!isExecuteSuccessfulIn) begin
          illegalNext = 1'b1;
          nextState   = IDLE;
        end else begin
          retire = 1'b1;
          // kill outranks a simultaneous taken jump
          if (killIn)         nextState = HALT;
          else if (didJumpIn) begin
            nextState = FLUSH;
            takeJump  = 1'b1;
          end else            nextState = IDLE;
        end
      end
      MUL_WAIT: begin
        if (!wbStallIn) begin
          if (mulCnt <= 3'd1) nextState  = EXEC;
          else                mulCntNext = mulCnt - 3'd1;
        end
      end
      FLUSH:   nextState = IDLE;
      HALT:    nextState = HALT;
      default: nextState = IDLE;
    endcase

    // accept only occurs from IDLE or a clean completion, so it overrides here
    if (accept) begin
      if (isMul && MUL_LATENCY > 1) begin
        nextState  = MUL_WAIT;
        mulCntNext = MUL_INIT;
      end else begin
        nextState  = EXEC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      mulCnt           <= '0;
      canExecuteOut    <= 1'b0;
      mulBusyOut       <= 1'b0;
      flushOut         <= 1'b0;
      redirectValidOut <= 1'b0;
      redirectRipOut   <= '0;
      haltedOut        <= 1'b0;
      illegalOut       <= 1'b0;
      retiredCountOut  <= '0;
    end else begin
      state            <= nextState;
      mulCnt           <= mulCntNext;
      canExecuteOut    <= (nextState == EXEC);
      mulBusyOut       <= (nextState == MUL_WAIT);
      flushOut         <= (nextState == FLUSH);
      redirectValidOut <= (nextState == FLUSH);
      haltedOut        <= (nextState == HALT);
      illegalOut       <= illegalNext;
      if (takeJump) redirectRipOut  <= jumpTargetIn;
      if (retire)   retiredCountOut <= retiredCountOut + 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_ctrl.sv
// Randomized and directed bench for execute_ctrl against an
// instruction-level reference model of the controller.
module tb_execute_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          decValidIn = 1'b0;
  logic          decReadyOut;
  logic [7:0]    opcodeIn = '0;
  logic [31:0]   opcodeLengthIn = 32'd1;
  logic          hasExtendedOpcodeIn = 1'b0;
  logic [2:0]    extendedOpcodeIn = '0;
  logic          wbStallIn = 1'b0;
  logic          isExecuteSuccessfulIn = 1'b0;
  logic          didJumpIn = 1'b0;
  logic [63:0]   jumpTargetIn = '0;
  logic          killIn = 1'b0;
  logic          latchEnOut, canExecuteOut, flushOut, redirectValidOut;
  logic [63:0]   redirectRipOut;
  logic          haltedOut, illegalOut, mulBusyOut;
  logic [CW-1:0] retiredCountOut;

  execute_ctrl #(.MUL_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .decValidIn(decValidIn), .decReadyOut(decReadyOut),
    .opcodeIn(opcodeIn), .opcodeLengthIn(opcodeLengthIn),
    .hasExtendedOpcodeIn(hasExtendedOpcodeIn), .extendedOpcodeIn(extendedOpcodeIn),
    .wbStallIn(wbStallIn), .isExecuteSuccessfulIn(isExecuteSuccessfulIn),
    .didJumpIn(didJumpIn), .jumpTargetIn(jumpTargetIn), .killIn(killIn),
    .latchEnOut(latchEnOut), .canExecuteOut(canExecuteOut), .flushOut(flushOut),
    .redirectValidOut(redirectValidOut), .redirectRipOut(redirectRipOut),
    .haltedOut(haltedOut), .illegalOut(illegalOut), .mulBusyOut(mulBusyOut),
    .retiredCountOut(retiredCountOut)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Model: one optional instruction in flight, with cycles left before it executes.
  bit          mInFlight, mHalt, mFlush, mIll;
  int          mWait;
  logic [CW-1:0] mCnt;
  logic [63:0] mRip;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit refIsMul(input logic [31:0] len, input logic [7:0] op,
                                  input bit hx, input logic [2:0] xo);
    if (len == 1 && (op == 8'h6B || op == 8'h69)) return 1'b1;
    if (len == 1 && op == 8'hF7 && hx && (xo == 3'd4 || xo == 3'd5)) return 1'b1;
    if (len == 2 && op == 8'hAF) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [7:0] op, input logic [31:0] len,
                       input bit hx, input logic [2:0] xo, input bit wb, input bit sc,
                       input bit jp, input logic [63:0] tg, input bit kl);
    bit rdy, acc;
    @(negedge clk);
    reset_n = r; decValidIn = v; opcodeIn = op; opcodeLengthIn = len;
    hasExtendedOpcodeIn = hx; extendedOpcodeIn = xo; wbStallIn = wb;
    isExecuteSuccessfulIn = sc; didJumpIn = jp; jumpTargetIn = tg; killIn = kl;
    rdy = r && !wb && !mHalt && !mFlush &&
          (!mInFlight || (mWait == 0 && sc && !jp && !kl));
    acc = v && rdy;
    #1;
    chk("decReady", decReadyOut, rdy);
    chk("latchEn", latchEnOut, acc);
    @(posedge clk);
    mIll = 0;
    if (!r) begin
      mInFlight = 0; mHalt = 0; mFlush = 0; mWait = 0; mCnt = '0; mRip = '0;
    end else if (!mHalt) begin
      if (mFlush) mFlush = 0;
      else if (mInFlight && mWait > 0) begin
        if (!wb) mWait--;
      end else if (mInFlight && !wb) begin
        mInFlight = 0;
        if (!sc) mIll = 1;
        else begin
          mCnt++;
          if (kl) mHalt = 1;
          else if (jp) begin mFlush = 1; mRip = tg; end
        end
      end
      if (acc) begin
        mInFlight = 1;
        mWait = refIsMul(len, op, hx, xo) ? LAT - 1 : 0;
      end
    end
    #1;
    chk("canExecute", canExecuteOut, mInFlight && mWait == 0);
    chk("mulBusy", mulBusyOut, mInFlight && mWait > 0);
    chk("flush", flushOut, mFlush);
    chk("redirectValid", redirectValidOut, mFlush);
    chk("redirectRip", redirectRipOut, mRip);
    chk("halted", haltedOut, mHalt);
    chk("illegal", illegalOut, mIll);
    chk("retired", retiredCountOut, mCnt);
  endtask

  // idle cycle helper: no new instruction offered
  task automatic tick(input bit r, input bit wb, input bit sc);
    cycle(r, 0, 8'h90, 1, 0, 0, wb, sc, 0, 0, 0);
  endtask

  logic [7:0] ops [8] = '{8'h01, 8'hF7, 8'h6B, 8'h69, 8'hAF, 8'h74, 8'hC3, 8'h0F};

  initial begin
    mInFlight = 0; mHalt = 0; mFlush = 0; mIll = 0; mWait = 0; mCnt = '0; mRip = '0;

    // reset held with Decode offering
    repeat (3) cycle(0, 1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0);

    // four back-to-back ADDs, then drain
    repeat (4) cycle(1, 1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0);
    tick(1, 0, 1);
    chk("addCount", retiredCountOut, 4);

    // MUL F7 /4 with a writeback stall pulse in the wait window
    cycle(1, 1, 8'hF7, 1, 1, 3'd4, 0, 1, 0, 0, 0);
    tick(1, 0, 1); tick(1, 1, 1); tick(1, 0, 1);
    chk("mulNotYet", canExecuteOut, 0);
    tick(1, 0, 1);
    chk("mulExec", canExecuteOut, 1);
    tick(1, 0, 1);

    // taken JE flushes and redirects
    cycle(1, 1, 8'h74, 1, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 1, 8'h01, 1, 0, 0, 0, 1, 1, 64'h400010, 0);
    chk("jeRip", redirectRipOut, 64'h400010);
    chk("jeFlush", flushOut, 1);
    tick(1, 0, 1);

    // unsupported opcode fails execution
    cycle(1, 1, 8'h0F, 1, 0, 0, 0, 1, 0, 0, 0);
    tick(1, 0, 0);
    chk("illPulse", illegalOut, 1);
    chk("illCount", retiredCountOut, 6);
    tick(1, 0, 0);

    // RET with simultaneous jump halts without flushing
    cycle(1, 1, 8'hC3, 1, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 8'h90, 1, 0, 0, 0, 1, 1, 64'h1234, 1);
    chk("retFlush", flushOut, 0);
    repeat (3) cycle(1, 1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0);
    chk("retHalted", haltedOut, 1);
    chk("retCount", retiredCountOut, 7);

    // counter wrap: 17 retirements on a 4-bit counter
    tick(0, 0, 0);
    repeat (17) cycle(1, 1, 8'h01, 1, 0, 0, 0, 1, 0, 0, 0);
    tick(1, 0, 1);
    chk("wrap", retiredCountOut, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = !((mHalt && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0);
      cycle(r, $urandom_range(0, 9) < 7, ops[$urandom_range(0, 7)], $urandom_range(1, 2),
            1'($urandom), 3'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 9,
            $urandom_range(0, 9) < 1, {$urandom, $urandom}, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/execute_ctrl.md
Name: execute_ctrl

Overview:
- Sequencing controller for the Execute stage.
- Accepts decoded instructions from Decode via a valid/ready handshake and drives the Execute `canExecuteIn` enable.
- Inserts fixed multi-cycle latency for multiply opcodes and holds while writeback stalls.
- On a taken jump, issues a one-cycle flush/redirect; on a return/kill opcode, halts the pipe.

Parameters:
- MUL_LATENCY, 4, cycles from accept to `canExecuteOut` for multiply opcodes; legal range 1..7 (1 behaves as single-cycle).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk
- decValidIn  in  1  Decode presents an instruction
- decReadyOut  out  1  controller can accept this cycle
- opcodeIn  in  8  decoded opcode byte
- opcodeLengthIn  in  32  opcode length in bytes
- hasExtendedOpcodeIn  in  1  ModRM.reg extension present
- extendedOpcodeIn  in  3  ModRM.reg extension value
- wbStallIn  in  1  writeback stall
- isExecuteSuccessfulIn  in  1  Execute completed the current instruction
- didJumpIn  in  1  Execute resolved a taken jump
- jumpTargetIn  in  64  jump target RIP
- killIn  in  1  Execute saw a return/kill opcode
- latchEnOut  out  1  load the Decode→Execute pipeline register
- canExecuteOut  out  1  registered; drives Execute `canExecuteIn`
- flushOut  out  1  registered one-cycle flush of fetch/decode
- redirectValidOut  out  1  registered; asserted with flushOut
- redirectRipOut  out  64  registered redirect target
- haltedOut  out  1  registered; sticky halt indicator
- illegalOut  out  1  registered one-cycle pulse on unsupported opcode
- mulBusyOut  out  1  registered; high while in MUL_WAIT
- retiredCountOut  out  CNT_W  registered retired-instruction count

Behaviour:
- Reset: state=IDLE, counter=0. canExecuteOut, flushOut, redirectValidOut, haltedOut, illegalOut and mulBusyOut are 0; redirectRipOut=0; retiredCountOut=0. decReadyOut=0 while reset_n=0.
- Reset mid-operation aborts any state, including HALT, on the next edge.
- isMul = (len==1 && op==F7 && ext && extOp∈{100,101}) || (len==1 && op∈{6B,69}) || (len==2 && op==AF).
- done = state==EXEC && isExecuteSuccessfulIn && !wbStallIn.
- decReadyOut (combinational) = reset_n && !wbStallIn && (state==IDLE || (done && !didJumpIn && !killIn)).
- accept = decValidIn && decReadyOut; latchEnOut = accept in the same cycle.
- On accept at cycle T:
  - Non-mul: next state EXEC; canExecuteOut=1 at T+1.
  - Mul with MUL_LATENCY>1: next state MUL_WAIT, counter=MUL_LATENCY-1; canExecuteOut=1 first at T+MUL_LATENCY.
- MUL_WAIT:
  - mulBusyOut=1, canExecuteOut=0.
  - Counter decrements each cycle with wbStallIn=0 and freezes while wbStallIn=1.
  - counter==1 and !wbStallIn → EXEC.
- EXEC, evaluated in priority order:
  1. wbStallIn=1: hold state and canExecuteOut=1; no accept.
  2. killIn && done: → HALT; retire.
  3. didJumpIn && done: → FLUSH; latch jumpTargetIn into redirectRipOut; retire.
  4. done: retire; → EXEC/MUL_WAIT if accept, else IDLE.
  5. !isExecuteSuccessfulIn: illegalOut pulses next cycle; → IDLE; no retire.
- Kill has priority over a simultaneous jump.
- FLUSH (exactly one cycle): flushOut=1, redirectValidOut=1, canExecuteOut=0, decReadyOut=0; → IDLE.
- HALT: terminal until reset. haltedOut=1, canExecuteOut=0, decReadyOut=0; all inputs ignored.
- IDLE: canExecuteOut=0.
- Retire: retiredCountOut+1 on the following edge; wraps modulo 2^CNT_W.

Decomposition:
- Package execute_ctrl_pkg:
  - state enum {IDLE, EXEC, MUL_WAIT, FLUSH, HALT}
  - opcode constants F7, 6B, 69, AF, 74, C3, CB, CF
  - function is_mul_op(len, op, hasExt, extOp)
- Sub-module exec_op_classifier: combinational isMul decode, reused by the hazard unit.

Test Plan:
- Reset: hold reset_n=0 three cycles with decValidIn=1 → all outputs 0, decReadyOut=0. Release → decReadyOut=1 in the next cycle.
- Back-to-back ADD (op 01, len 1): isExecuteSuccessfulIn=1 every cycle, 4 instructions → canExecuteOut continuously 1 after the first accept, 4 latchEnOut pulses, retiredCountOut=4.
- MUL (F7 /4), MUL_LATENCY=4, accept at T → mulBusyOut 1 for T+1..T+3, canExecuteOut=1 at T+4. A wbStallIn pulse at T+2 delays canExecuteOut to T+5.
- JE (op 74) with didJumpIn=1 and jumpTargetIn=0x400010 → next cycle flushOut=1, redirectValidOut=1, redirectRipOut=0x400010, decReadyOut=0; then IDLE.
- RET (C3) with killIn=1 and didJumpIn=1 in the same cycle → HALT, flushOut stays 0, haltedOut=1 sticky. Further decValidIn is ignored until reset_n=0.
- Wrap and illegal:
  - CNT_W=4, 17 retirements → retiredCountOut=1.
  - Unsupported op with isExecuteSuccessfulIn=0 → illegalOut one-cycle pulse, state IDLE, count unchanged.
